// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: mode encodings and the
// channel-select width helper.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // A single channel still needs a one-bit select port.
  function automatic int ch_sel_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter, direction flag and
// period boundary detection with a registered period_start pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   top,
  output logic [WIDTH-1:0]   counter,
  output logic               boundary,
  output logic               period_start
);

  logic [PRESC_W-1:0] presc_cnt;
  logic               down;
  logic [WIDTH-1:0]   active_top;
  logic               active_mode;
  logic               tick;
  logic [WIDTH-1:0]   counter_next;
  logic               down_next;

  // boundary is the tick on which the counter returns to 0 for a new period.
  always_comb begin
    tick         = en && (presc_cnt == prescale);
    counter_next = counter;
    down_next    = down;
    boundary     = 1'b0;
    if (tick) begin
      if (active_top == '0) begin
        counter_next = '0;
        boundary     = 1'b1;
      end else if (active_mode == MODE_EDGE) begin
        if (counter == active_top) begin
          counter_next = '0;
          boundary     = 1'b1;
        end else begin
          counter_next = counter + 1'b1;
        end
      end else if (!down) begin
        if (counter == active_top) begin
          counter_next = counter - 1'b1;
          down_next    = 1'b1;
        end else begin
          counter_next = counter + 1'b1;
        end
      end else begin
        counter_next = counter - 1'b1;
        if (counter == WIDTH'(1)) begin
          boundary  = 1'b1;
          down_next = 1'b0;
        end
      end
    end
  end

  // While disabled the period limit and mode track their inputs every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      counter      <= '0;
      down         <= 1'b0;
      active_top   <= '0;
      active_mode  <= MODE_EDGE;
      period_start <= 1'b0;
    end else if (!en) begin
      presc_cnt    <= '0;
      counter      <= '0;
      down         <= 1'b0;
      active_top   <= top;
      active_mode  <= mode;
      period_start <= 1'b0;
    end else begin
      presc_cnt    <= tick ? '0 : presc_cnt + 1'b1;
      counter      <= counter_next;
      period_start <= boundary;
      if (boundary) begin
        active_top  <= top;
        active_mode <= mode;
        down        <= 1'b0;
      end else begin
        down <= down_next;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase plus per-channel
// double-buffered duty registers and registered comparator outputs.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int PRESC_W  = 4,
  localparam int CH_W     = ch_sel_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic [WIDTH-1:0]    top,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [WIDTH-1:0]    counter,
  output logic                period_start,
  output logic [CHANNELS-1:0] pwm_out
);

  logic                boundary;
  logic                load;
  logic [CHANNELS-1:0] below;

  pwm_timebase #(
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .prescale    (prescale),
    .top         (top),
    .counter     (counter),
    .boundary    (boundary),
    .period_start(period_start)
  );

  assign load = boundary || !en;

  // Selects beyond the last channel match no channel and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_duty;
    logic [WIDTH-1:0] active_duty;
    logic             hit;

    assign hit = wr_en && (wr_ch == CH_W'(i));

    // A write landing on a load cycle goes straight into the active copy.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_duty <= '0;
        active_duty <= '0;
      end else begin
        if (hit) shadow_duty <= wr_duty;
        if (load) active_duty <= hit ? wr_duty : shadow_duty;
      end
    end

    assign below[i] = counter < active_duty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= en ? below : '0;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: a cycle reference model fills a
// scoreboard queue, compared each falling edge, plus directed period checks.
module tb_pwm_multi;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [3:0] prescale;
  logic [7:0] top;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_duty;
  logic [7:0] counter;
  logic       period_start;
  logic [3:0] pwm_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic       ps;
    logic [3:0] pwm;
  } exp_t;

  exp_t sb[$];

  pwm_multi #(
    .WIDTH   (8),
    .CHANNELS(4),
    .PRESC_W (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .prescale    (prescale),
    .top         (top),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .counter     (counter),
    .period_start(period_start),
    .pwm_out     (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model state, written only by the model process.
  logic [7:0] m_cnt, m_top;
  logic [3:0] m_pre;
  logic       m_down, m_mode, m_ps;
  logic [3:0] m_pwm;
  logic [7:0] m_shadow[4];
  logic [7:0] m_active[4];

  always @(posedge clk) begin : model
    logic [3:0] nxt_pwm;
    logic       bnd;
    if (!rst_n) begin
      m_cnt = 0; m_top = 0; m_pre = 0; m_down = 0; m_mode = 0; m_ps = 0; m_pwm = 0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) nxt_pwm[i] = en && (m_cnt < m_active[i]);
      if (wr_en) m_shadow[wr_ch] = wr_duty;
      bnd = 1'b0;
      if (!en) begin
        m_cnt = 0; m_pre = 0; m_down = 0; m_ps = 0;
        m_top = top; m_mode = mode;
        for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
      end else begin
        if (m_pre == prescale) begin
          m_pre = 0;
          if (m_top == 0) begin
            bnd = 1'b1;
          end else if (m_mode == 1'b0) begin
            if (m_cnt == m_top) begin m_cnt = 0; bnd = 1'b1; end
            else m_cnt = m_cnt + 8'd1;
          end else if (!m_down) begin
            if (m_cnt == m_top) begin m_down = 1'b1; m_cnt = m_cnt - 8'd1; end
            else m_cnt = m_cnt + 8'd1;
          end else begin
            m_cnt = m_cnt - 8'd1;
            if (m_cnt == 0) bnd = 1'b1;
          end
        end else begin
          m_pre = m_pre + 4'd1;
        end
        m_ps = bnd;
        if (bnd) begin
          m_top = top; m_mode = mode; m_down = 1'b0;
          for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
        end
      end
      m_pwm = nxt_pwm;
    end
    sb.push_back(exp_t'{cnt: m_cnt, ps: m_ps, pwm: m_pwm});
  end

  always @(negedge clk) begin : scoreboard
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("sb_counter", 32'(counter), 32'(e.cnt));
      checkOutput("sb_period_start", 32'(period_start), 32'(e.ps));
      checkOutput("sb_pwm_out", 32'(pwm_out), 32'(e.pwm));
    end
  end

  task automatic applyStimulus(input logic en_v, input logic mode_v,
                               input logic [3:0] presc_v, input logic [7:0] top_v);
    @(negedge clk);
    en = en_v; mode = mode_v; prescale = presc_v; top = top_v;
  endtask

  // Caller must be at a falling edge; the strobe lasts one clock.
  task automatic writeDuty(input logic [1:0] ch, input logic [7:0] duty);
    wr_en = 1'b1; wr_ch = ch; wr_duty = duty;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic measurePeriod(input int ch, output int len, output int highs);
    int guard = 0;
    len = 0;
    highs = 0;
    @(negedge clk);
    while (!period_start && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!period_start) begin
      checkOutput("wait_period_start", 32'd0, 32'd1);
      return;
    end
    do begin
      highs += int'(pwm_out[ch]);
      len++;
      @(negedge clk);
    end while (!period_start && len < 300);
  endtask

  initial begin : stimulus
    int len, highs, guard;
    int seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; prescale = 4'd0; top = 8'd0;
    wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Edge mode, duty 3 of a 10-clock period.
    applyStimulus(1'b0, 1'b0, 4'd0, 8'd9);
    writeDuty(2'd0, 8'd3);
    en = 1'b1;
    measurePeriod(0, len, highs);
    checkOutput("edge_len", 32'(len), 32'd10);
    checkOutput("edge_highs", 32'(highs), 32'd3);

    // Mid-period duty change only shows after the next boundary.
    guard = 0;
    while (counter != 8'd5 && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("reach_counter5", 32'(counter), 32'd5);
    writeDuty(2'd0, 8'd7);
    measurePeriod(0, len, highs);
    checkOutput("dbuf_len", 32'(len), 32'd10);
    checkOutput("dbuf_highs", 32'(highs), 32'd7);

    // Center mode, top 4.
    applyStimulus(1'b1, 1'b1, 4'd0, 8'd4);
    writeDuty(2'd0, 8'd2);
    measurePeriod(0, len, highs);
    checkOutput("center_len", 32'(len), 32'd8);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("center_seq%0d", k), 32'(counter), 32'(seq[k]));
      @(negedge clk);
    end
    checkOutput("center_wrap_ps", 32'(period_start), 32'd1);

    // Extremes on ch1/ch2, mid duty on ch3.
    applyStimulus(1'b1, 1'b0, 4'd0, 8'd9);
    writeDuty(2'd1, 8'd0);
    writeDuty(2'd2, 8'd255);
    writeDuty(2'd3, 8'd5);
    measurePeriod(2, len, highs);
    measurePeriod(2, len, highs);
    checkOutput("ch2_always_high", 32'(highs), 32'(len));
    measurePeriod(1, len, highs);
    checkOutput("ch1_always_low", 32'(highs), 32'd0);
    measurePeriod(3, len, highs);
    checkOutput("ch3_highs", 32'(highs), 32'd5);

    // Prescaler: 4 clocks per count, 4 counts per period.
    applyStimulus(1'b1, 1'b0, 4'd3, 8'd3);
    measurePeriod(0, len, highs);
    checkOutput("presc_len", 32'(len), 32'd16);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 1) == 1);
      wr_ch = 2'($urandom_range(0, 3));
      wr_duty = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 8));
      if ($urandom_range(0, 39) == 0) begin
        top = 8'($urandom_range(0, 6));
        mode = 1'($urandom_range(0, 1));
        prescale = 4'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 59) == 0) en = ~en;
    end
    wr_en = 1'b0;

    // Asynchronous reset while counting with an output high.
    applyStimulus(1'b1, 1'b0, 4'd0, 8'd9);
    writeDuty(2'd0, 8'd4);
    guard = 0;
    while (!(pwm_out[0] && counter != 8'd0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("pre_reset_pwm0", 32'(pwm_out[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("async_counter", 32'(counter), 32'd0);
    checkOutput("async_pwm", 32'(pwm_out), 32'd0);
    checkOutput("async_ps", 32'(period_start), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measurePeriod(0, len, highs);
    measurePeriod(0, len, highs);
    checkOutput("post_reset_len", 32'(len), 32'd10);
    checkOutput("post_reset_ch0_low", 32'(highs), 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
